// File: rtl/mkgauss_pkg.sv
// Shared constants for the discrete-Gaussian sampler: the CDT thresholds
// and the mask that strips the top bit from each 64-bit random word.
package mkgauss_pkg;

  localparam int CDT_LEN  = 27;
  localparam int SAMPLE_W = 32;

  // Clears bit 63 so the remaining 63 bits compare as a non-negative value.
  localparam logic [63:0] MAG_MASK = 64'h7FFF_FFFF_FFFF_FFFF;

  // Cumulative distribution table gauss_1024_12289. Entry 0 is the
  // zero/non-zero threshold tested against r1; entries 1..26 are the
  // magnitude thresholds tested against r2.
  localparam logic [63:0] GAUSS_CDT [CDT_LEN] = '{
    64'd1283868770400643928, 64'd6416574995475331444, 64'd4078260278032692663,
    64'd2353523259288686585, 64'd1227179971273316331, 64'd575931623374121527,
    64'd242543240509105209,  64'd91437049221049666,   64'd30799446349977173,
    64'd9255276791179340,    64'd2478152334826140,    64'd590642893610164,
    64'd125206034929641,     64'd23590435911403,      64'd3948334035941,
    64'd586753615614,        64'd77391054539,         64'd9056793210,
    64'd940121950,           64'd86539696,            64'd7062824,
    64'd510971,              64'd32764,               64'd1862,
    64'd93,                  64'd4,                   64'd0
  };

endpackage

// File: rtl/mkgauss_cdt.sv
// Combinational CDT lookup: one subtract/compare per table entry followed
// by a priority encoder that picks the smallest index whose threshold the
// magnitude word meets, then applies the sign taken from r1.
module mkgauss_cdt
  import mkgauss_pkg::*;
(
  input  logic        [63:0]         r1,
  input  logic        [63:0]         r2,
  output logic signed [SAMPLE_W-1:0] val
);

  logic [63:0]         a;
  logic [63:0]         b;
  logic                neg;
  logic                a_lt;
  logic [CDT_LEN-1:1]  b_lt;
  logic [4:0]          mag;
  logic [SAMPLE_W-1:0] neg_mask;

  assign a   = r1 & MAG_MASK;
  assign b   = r2 & MAG_MASK;
  assign neg = r1[63];

  // "x < T" is the borrow seen in bit 63 of the 64-bit difference.
  assign a_lt = 1'((a - GAUSS_CDT[0]) >> 63);

  for (genvar k = 1; k < CDT_LEN; k++) begin : g_cmp
    assign b_lt[k] = 1'((b - GAUSS_CDT[k]) >> 63);
  end

  // Priority encode: smallest k with b >= T[k]; T[26] = 0 guarantees a hit.
  always_comb begin
    mag = 5'd26;
    for (int k = CDT_LEN - 1; k >= 1; k--) begin
      if (!b_lt[k]) mag = 5'(k);
    end
    if (a_lt) mag = 5'd0;
  end

  // Conditional negate as (v ^ -neg) + neg, so -0 stays 0.
  always_comb begin
    neg_mask = {SAMPLE_W{neg}};
    val      = signed'((SAMPLE_W'(mag) ^ neg_mask) + SAMPLE_W'(neg));
  end

endmodule

// File: rtl/mkgauss.sv
// Falcon mkgauss sampler (g = 1). Collects one r1 and one r2 word, which may
// arrive in either order or together, and emits one registered sample per
// completed pair as a single-cycle val_valid pulse.
//
// Handshake: r1_valid/r2_valid qualify their word for one cycle with no
// backpressure; a repeated word on one side overwrites the held one. The
// pair completes in the cycle both sides are present (live or held), and
// val_valid pulses on the following edge; the consumer must take it.
module mkgauss
  import mkgauss_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       r1_valid,
  input  logic        [63:0]         r1,
  input  logic                       r2_valid,
  input  logic        [63:0]         r2,
  output logic                       val_valid,
  output logic signed [SAMPLE_W-1:0] val
);

  logic                       have1;
  logic                       have2;
  logic        [63:0]         hold1;
  logic        [63:0]         hold2;
  logic        [63:0]         sel1;
  logic        [63:0]         sel2;
  logic                       complete;
  logic signed [SAMPLE_W-1:0] sample;

  // Live word takes priority over the held one on each side.
  assign sel1     = r1_valid ? r1 : hold1;
  assign sel2     = r2_valid ? r2 : hold2;
  assign complete = (have1 | r1_valid) & (have2 | r2_valid);

  mkgauss_cdt u_cdt (
    .r1  (sel1),
    .r2  (sel2),
    .val (sample)
  );

  // Capture words, retire complete pairs and register the sample.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      have1     <= 1'b0;
      have2     <= 1'b0;
      hold1     <= '0;
      hold2     <= '0;
      val       <= '0;
      val_valid <= 1'b0;
    end else if (complete) begin
      val       <= sample;
      val_valid <= 1'b1;
      have1     <= 1'b0;
      have2     <= 1'b0;
    end else begin
      val_valid <= 1'b0;
      if (r1_valid) begin
        hold1 <= r1;
        have1 <= 1'b1;
      end
      if (r2_valid) begin
        hold2 <= r2;
        have2 <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mkgauss.sv
// Bench for mkgauss: directed table-edge cases, split arrival, reset
// behaviour and randomized traffic against a software mkgauss model.
module tb_mkgauss;

  logic               clk;
  logic               rst_n;
  logic               r1_valid;
  logic [63:0]        r1;
  logic               r2_valid;
  logic [63:0]        r2;
  logic               val_valid;
  logic signed [31:0] val;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_q[$];

  // Independent copy of the CDT as plain unsigned integers.
  longint unsigned cdt [27] = '{
    64'd1283868770400643928, 64'd6416574995475331444, 64'd4078260278032692663,
    64'd2353523259288686585, 64'd1227179971273316331, 64'd575931623374121527,
    64'd242543240509105209,  64'd91437049221049666,   64'd30799446349977173,
    64'd9255276791179340,    64'd2478152334826140,    64'd590642893610164,
    64'd125206034929641,     64'd23590435911403,      64'd3948334035941,
    64'd586753615614,        64'd77391054539,         64'd9056793210,
    64'd940121950,           64'd86539696,            64'd7062824,
    64'd510971,              64'd32764,               64'd1862,
    64'd93,                  64'd4,                   64'd0
  };

  mkgauss dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .r1_valid  (r1_valid),
    .r1        (r1),
    .r2_valid  (r2_valid),
    .r2        (r2),
    .val_valid (val_valid),
    .val       (val)
  );

  // Clock and reset defaults
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Software mkgauss for g = 1.
  function automatic logic [31:0] ref_gauss(input logic [63:0] w1, input logic [63:0] w2);
    longint unsigned a;
    longint unsigned b;
    int v;
    a = {1'b0, w1[62:0]};
    b = {1'b0, w2[62:0]};
    v = 0;
    if (a >= cdt[0]) begin
      for (int k = 1; k <= 26; k++) begin
        if (b >= cdt[k]) begin
          v = k;
          break;
        end
      end
    end
    if (w1[63]) v = -v;
    return 32'(v);
  endfunction

  function automatic logic [63:0] rand64();
    return {$urandom(), $urandom()};
  endfunction

  // Drive one cycle of inputs; outputs are sampled 1 time unit after the edge.
  task automatic step(input logic v1, input logic [63:0] w1,
                      input logic v2, input logic [63:0] w2);
    r1_valid = v1;
    r1       = w1;
    r2_valid = v2;
    r2       = w2;
    @(posedge clk);
    #1;
    r1_valid = 1'b0;
    r2_valid = 1'b0;
  endtask

  task automatic check_idle(input string name, input logic [31:0] hold_val);
    checks++;
    if (val_valid !== 1'b0 || val !== hold_val) begin
      failures++;
      $display("FAIL %s: val_valid=%b val=%h, required val_valid=0 val=%h",
               name, val_valid, val, hold_val);
    end
  endtask

  task automatic check_pulse(input string name, input logic [31:0] expv);
    checks++;
    if (val_valid !== 1'b1 || val !== expv) begin
      failures++;
      $display("FAIL %s: val_valid=%b val=%h, required val_valid=1 val=%h",
               name, val_valid, val, expv);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1'($urandom_range(0, 1)), rand64(), 1'($urandom_range(0, 1)), rand64());
      check_idle("reset_hold", 32'd0);
    end
    rst_n = 1'b1;
    step(1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 64'd0);
    check_idle("reset_half_pair", 32'd0);
    rst_n = 1'b0;
    step(1'b0, 64'd0, 1'b0, 64'd0);
    check_idle("reset_discard", 32'd0);
    rst_n = 1'b1;
    step(1'b0, 64'd0, 1'b1, 64'd0);
    check_idle("reset_r2_alone", 32'd0);
    step(1'b0, 64'd0, 1'b0, 64'd0);
    check_idle("reset_r2_alone_next", 32'd0);
  endtask

  // Same-cycle pair, then an idle cycle where val must hold.
  task automatic directed(input string name, input logic [63:0] w1,
                          input logic [63:0] w2, input logic [31:0] expv);
    step(1'b1, w1, 1'b1, w2);
    check_pulse(name, expv);
    step(1'b0, 64'd0, 1'b0, 64'd0);
    check_idle({name, "_hold"}, expv);
  endtask

  task automatic test_table_edges();
    directed("base_r1_zero",     64'd0,                  rand64(),               32'd0);
    directed("base_neg_zero",    64'h8000_0000_0000_0000, rand64(),              32'd0);
    directed("tail_pos",         64'h7FFF_FFFF_FFFF_FFFF, 64'd0,                 32'd26);
    directed("tail_neg",         64'hFFFF_FFFF_FFFF_FFFF, 64'd0,                 32'hFFFF_FFE6);
    directed("head",             64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 32'd1);
    directed("t1_exact",         64'h7FFF_FFFF_FFFF_FFFF, 64'd6416574995475331444, 32'd1);
    directed("t1_minus",         64'h7FFF_FFFF_FFFF_FFFF, 64'd6416574995475331443, 32'd2);
    directed("t1_top_bit_ignored", 64'h7FFF_FFFF_FFFF_FFFF,
             64'h8000_0000_0000_0000 | 64'd6416574995475331443,                  32'd2);
    directed("t24_exact",        64'h7FFF_FFFF_FFFF_FFFF, 64'd93,                32'd24);
    directed("t24_minus",        64'h7FFF_FFFF_FFFF_FFFF, 64'd92,                32'd25);
    directed("t0_minus",         64'd1283868770400643927, 64'd0,                 32'd0);
    directed("t0_exact",         64'd1283868770400643928, 64'd0,                 32'd26);
    directed("neg_mid",          64'hFFFF_FFFF_FFFF_FFFF, 64'd1862,              32'hFFFF_FFE9);
  endtask

  task automatic test_split_arrival();
    logic [63:0] wa;
    logic [63:0] wb;
    logic [63:0] wc;
    logic [63:0] wd;
    logic [31:0] last;
    wa = 64'h7FFF_FFFF_FFFF_FFFF;
    wb = 64'd510971;
    wc = 64'hFFFF_FFFF_FFFF_FFFF;
    wd = 64'd4;
    last = val;
    step(1'b0, 64'd0, 1'b1, wb);
    check_idle("split_c0", last);
    step(1'b0, 64'd0, 1'b0, 64'd0);
    check_idle("split_c1", last);
    step(1'b0, 64'd0, 1'b0, 64'd0);
    check_idle("split_c2", last);
    step(1'b1, wa, 1'b0, 64'd0);
    check_pulse("split_pulse", ref_gauss(wa, wb));
    step(1'b1, wc, 1'b0, 64'd0);
    check_idle("split_no_second", ref_gauss(wa, wb));
    step(1'b0, 64'd0, 1'b0, 64'd0);
    check_idle("split_wait", ref_gauss(wa, wb));
    step(1'b0, 64'd0, 1'b1, wd);
    check_pulse("split_held_r1", ref_gauss(wc, wd));
  endtask

  task automatic test_back_to_back();
    logic [63:0] w1;
    logic [63:0] w2;
    for (int i = 0; i < 20; i++) begin
      w1 = rand64();
      w2 = rand64() >> $urandom_range(0, 63);
      step(1'b1, w1, 1'b1, w2);
      check_pulse("back_to_back", ref_gauss(w1, w2));
    end
  endtask

  // Randomized traffic: the bench tracks the pending word per side and
  // queues the expected sample whenever a pair completes.
  task automatic test_random();
    logic        have1;
    logic        have2;
    logic [63:0] p1;
    logic [63:0] p2;
    logic        v1;
    logic        v2;
    logic [63:0] w1;
    logic [63:0] w2;
    logic [31:0] last;
    logic [31:0] expv;
    int          pairs;
    have1 = 1'b0;
    have2 = 1'b0;
    p1 = '0;
    p2 = '0;
    pairs = 0;
    last = val;
    for (int cyc = 0; cyc < 20000 && pairs < 1000; cyc++) begin
      v1 = ($urandom_range(0, 99) < 55);
      v2 = ($urandom_range(0, 99) < 55);
      w1 = rand64();
      w2 = rand64() >> $urandom_range(0, 63);
      if ((have1 || v1) && (have2 || v2)) begin
        exp_q.push_back(ref_gauss(v1 ? w1 : p1, v2 ? w2 : p2));
        have1 = 1'b0;
        have2 = 1'b0;
        pairs++;
      end else begin
        if (v1) begin p1 = w1; have1 = 1'b1; end
        if (v2) begin p2 = w2; have2 = 1'b1; end
      end
      step(v1, w1, v2, w2);
      if (exp_q.size() != 0) begin
        expv = exp_q.pop_front();
        check_pulse("random_pair", expv);
        last = expv;
      end else begin
        check_idle("random_idle", last);
      end
    end
    checks++;
    if (pairs != 1000) begin
      failures++;
      $display("FAIL random_budget: pairs=%0d, required 1000", pairs);
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    r1_valid = 1'b0;
    r2_valid = 1'b0;
    r1       = '0;
    r2       = '0;
    test_reset();
    test_table_edges();
    test_split_arrival();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
